// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS integer-subset core.
// One ALU and one unified instruction/data port are shared across the
// FETCH / DECODE / EXEC / MEM / WB states.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unsupported
// instruction halts the core. When it is undefined, the instruction is a NOP.
//
// Memory handshake: mem_req is raised in FETCH and MEM. While mem_req=1 and
// mem_ack=0, mem_addr, mem_we and mem_wdata hold their values. A cycle with
// mem_req=1 and mem_ack=1 completes the access on that rising edge, and
// mem_rdata is sampled on the same edge. mem_ack is ignored while mem_req=0.
// Reset drops mem_req without an ack, so the memory must tolerate an
// abandoned access.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          NREGS    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [31:0]       pc_dbg,
    output logic [2:0]        stateDbg
);

    // With 16 registers the top bit of each register index is ignored.
    localparam int IW = (NREGS == 16) ? 4 : 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } stateT;

    stateT       state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] aluOut;
    logic [31:0] mdr;
    logic [31:0] regFile [NREGS];

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] signExt;
    logic [31:0] zeroExt;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign funct   = ir[5:0];
    assign imm     = ir[15:0];
    assign signExt = {{16{imm[15]}}, imm};
    assign zeroExt = {16'h0000, imm};

    logic isRType;
    logic isLw;
    logic isSw;
    logic isBeq;
    logic isBne;
    logic isJ;
    logic isLegal;
    logic taken;

    assign isRType = (opcode == OP_RTYPE);
    assign isLw    = (opcode == OP_LW);
    assign isSw    = (opcode == OP_SW);
    assign isBeq   = (opcode == OP_BEQ);
    assign isBne   = (opcode == OP_BNE);
    assign isJ     = (opcode == OP_J);
    assign taken   = (isBeq && (regA == regB)) || (isBne && (regA != regB));

    // The PC has already been advanced past the instruction in both cases.
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    assign branchTarget = pc + {signExt[29:0], 2'b00};
    assign jumpTarget   = {pc[31:28], ir[25:0], 2'b00};

    logic [4:0]  wbDest;
    logic [31:0] wbData;
    assign wbDest = isRType ? rd : rt;
    assign wbData = isLw ? mdr : aluOut;

    // $0 is never written, so reading it always gives the reset value 0.
    function automatic logic [31:0] regRead(input logic [4:0] idx);
        return regFile[idx[IW-1:0]];
    endfunction

    // Classify the opcode/funct pair as inside or outside the subset
    always_comb begin
        isLegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_ADDU, FN_SUBU,
                    FN_AND, FN_OR, FN_SLT: isLegal = 1'b1;
                    default:               isLegal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: isLegal = 1'b1;
            default:                      isLegal = 1'b0;
        endcase
    end

    // Shared ALU: operates on the A/B latches and the immediate
    logic [31:0] aluResult;
    always_comb begin
        aluResult = 32'h0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: aluResult = regA + regB;
                    FN_SUBU: aluResult = regA - regB;
                    FN_AND:  aluResult = regA & regB;
                    FN_OR:   aluResult = regA | regB;
                    FN_SLT:  aluResult = {31'h0, ($signed(regA) < $signed(regB))};
                    FN_SLL:  aluResult = regB << shamt;
                    FN_SRL:  aluResult = regB >> shamt;
                    default: aluResult = 32'h0;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: aluResult = regA + signExt;
            OP_ANDI:                aluResult = regA & zeroExt;
            OP_ORI:                 aluResult = regA | zeroExt;
            OP_LUI:                 aluResult = {imm, 16'h0000};
            default:                aluResult = 32'h0;
        endcase
    end

    // Main sequencer: state, PC, datapath latches and register file
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= 32'h0;
            regA   <= 32'h0;
            regB   <= 32'h0;
            aluOut <= 32'h0;
            mdr    <= 32'h0;
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= 32'h0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    regA <= regRead(rs);
                    regB <= regRead(rt);
                    if (!isLegal) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= HALT;
`else
                        state <= FETCH;
`endif
                    end else if (isJ) begin
                        pc    <= jumpTarget;
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    aluOut <= aluResult;
                    if (isBeq || isBne) begin
                        if (taken) begin
                            pc <= branchTarget;
                        end
                        state <= FETCH;
                    end else if (isLw || isSw) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (isLw) begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (wbDest[IW-1:0] != '0) begin
                        regFile[wbDest[IW-1:0]] <= wbData;
                    end
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Memory port decode; held idle while reset is asserted
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        if (!RST) begin
            if (state == FETCH) begin
                mem_req  = 1'b1;
                mem_addr = {pc[ADDR_W-1:2], 2'b00};
            end else if (state == MEM) begin
                mem_req  = 1'b1;
                mem_we   = isSw;
                mem_addr = {aluOut[ADDR_W-1:2], 2'b00};
            end
        end
    end

    assign mem_wdata = regB;
    assign pc_dbg    = pc;
    assign stateDbg  = state;

`ifdef ILLEGAL_TRAP_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
